// File: rtl/c1_joy_cond.sv
// Player control conditioning for the C1 input ports: sync, debounce, SOCD, invert.
// Optional autofire on buttons A..D is built when C1_AUTOFIRE_EN is defined.
module c1_joy_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTOFIRE_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VBLANK,
  input  logic [9:0] JOY1_RAW,
  input  logic [9:0] JOY2_RAW,
  input  logic [3:0] AUTOFIRE1,
  input  logic [3:0] AUTOFIRE2,
  output logic [9:0] P1_IN,
  output logic [9:0] P2_IN
);

  localparam int unsigned NBITS = 20;
  localparam int unsigned CW    = 8;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0]         sync1_q, sync_q;
  logic [NBITS-1:0]         stab_q, stab_d;
  logic [NBITS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [9:0]               p1_d, p2_d;
  logic [9:0]               socd1, socd2;

  // Clear an opposing direction pair when both are held; buttons pass through.
  function automatic logic [9:0] socd(input logic [9:0] s);
    logic [9:0] r;
    r = s;
    if (s[0] && s[1]) r[1:0] = 2'b00;
    if (s[2] && s[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  // Per-bit debounce: stab follows sync only after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    stab_d = stab_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NBITS; i++) begin
      if (sync_q[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        stab_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign socd1 = socd(stab_q[9:0]);
  assign socd2 = socd(stab_q[19:10]);

`ifdef C1_AUTOFIRE_EN
  localparam logic [3:0] AF_LAST = 4'(AUTOFIRE_FRAMES - 1);

  logic       vb_prev_q;
  logic [3:0] af_cnt_q, af_cnt_d;
  logic       phase_q, phase_d;

  // Frame counter advances on VBLANK rising edges; phase toggles every AUTOFIRE_FRAMES.
  always_comb begin
    af_cnt_d = af_cnt_q;
    phase_d  = phase_q;
    if (VBLANK && !vb_prev_q) begin
      if (af_cnt_q == AF_LAST) begin
        af_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        af_cnt_d = af_cnt_q + 4'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vb_prev_q <= 1'b0;
      af_cnt_q  <= '0;
      phase_q   <= 1'b0;
    end else begin
      vb_prev_q <= VBLANK;
      af_cnt_q  <= af_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // Autofire-enabled buttons only read pressed during the high phase.
  always_comb begin
    p1_d = socd1;
    p2_d = socd2;
    p1_d[7:4] = socd1[7:4] & (~AUTOFIRE1 | {4{phase_q}});
    p2_d[7:4] = socd2[7:4] & (~AUTOFIRE2 | {4{phase_q}});
  end
`else
  logic unused_ok;
  assign unused_ok = ^{VBLANK, AUTOFIRE1, AUTOFIRE2, 4'(AUTOFIRE_FRAMES)};

  always_comb begin
    p1_d = socd1;
    p2_d = socd2;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= '0;
      sync_q  <= '0;
      stab_q  <= '0;
      cnt_q   <= '0;
      P1_IN   <= 10'h3FF;
      P2_IN   <= 10'h3FF;
    end else begin
      sync1_q <= {JOY2_RAW, JOY1_RAW};
      sync_q  <= sync1_q;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      P1_IN   <= ~p1_d;
      P2_IN   <= ~p2_d;
    end
  end

endmodule

// File: tb/tb_c1_joy_cond.sv
// Scoreboard bench for c1_joy_cond: a behavioural model predicts P1_IN/P2_IN each cycle.
// Autofire directed/model paths are enabled when C1_AUTOFIRE_EN is defined.
module tb_c1_joy_cond;
  localparam int unsigned DEB = 4;
  localparam int unsigned AF  = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       VBLANK;
  logic [9:0] JOY1_RAW, JOY2_RAW;
  logic [3:0] AUTOFIRE1, AUTOFIRE2;
  logic [9:0] P1_IN, P2_IN;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  c1_joy_cond #(.DEBOUNCE_CYCLES(DEB), .AUTOFIRE_FRAMES(AF)) dut (
    .CLK(CLK), .RESET(RESET), .VBLANK(VBLANK),
    .JOY1_RAW(JOY1_RAW), .JOY2_RAW(JOY2_RAW),
    .AUTOFIRE1(AUTOFIRE1), .AUTOFIRE2(AUTOFIRE2),
    .P1_IN(P1_IN), .P2_IN(P2_IN)
  );

  // Expected {P2_IN, P1_IN} after each clock edge.
  logic [19:0] sb[$];

  // Model state: raw samples in flight, recent synchronised samples, stable levels.
  logic [19:0] m_s1, m_s2, m_stab;
  logic [19:0] m_hist[$];
  int          m_rises;
  logic        m_vprev;

  function automatic logic [9:0] ref_player(input logic [9:0] s, input logic [3:0] af,
                                            input logic ph);
    logic [9:0] r;
    r = s;
    if (s[0] && s[1]) r[1:0] = 2'b00;
    if (s[2] && s[3]) r[3:2] = 2'b00;
`ifdef C1_AUTOFIRE_EN
    for (int k = 0; k < 4; k++)
      if (af[k]) r[4+k] = s[4+k] & ph;
`else
    if (af === 4'hx && ph === 1'bx) r = 10'hx;
`endif
    return ~r;
  endfunction

  always @(posedge CLK) begin : model
    logic ph;
    logic all_diff;
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0;
      m_hist.delete();
      m_rises = 0; m_vprev = 1'b0;
      sb.push_back(20'hFFFFF);
    end else begin
      ph = ((m_rises / int'(AF)) % 2) == 1;
      sb.push_back({ref_player(m_stab[19:10], AUTOFIRE2, ph),
                    ref_player(m_stab[9:0], AUTOFIRE1, ph)});
      m_hist.push_front(m_s2);
      if (m_hist.size() > int'(DEB)) void'(m_hist.pop_back());
      if (m_hist.size() == int'(DEB)) begin
        for (int b = 0; b < 20; b++) begin
          all_diff = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_stab[b]) all_diff = 1'b0;
          if (all_diff) m_stab[b] = ~m_stab[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = {JOY2_RAW, JOY1_RAW};
      if (VBLANK && !m_vprev) m_rises++;
      m_vprev = VBLANK;
    end
  end

  always @(negedge CLK) begin : monitor
    logic [19:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (P1_IN !== e[9:0]) begin
        bad++;
        $display("FAIL sb_p1 t=%0t got=%h want=%h", $time, P1_IN, e[9:0]);
      end
      total++;
      if (P2_IN !== e[19:10]) begin
        bad++;
        $display("FAIL sb_p2 t=%0t got=%h want=%h", $time, P2_IN, e[19:10]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; VBLANK = 1'b0;
    JOY1_RAW = '0; JOY2_RAW = '0; AUTOFIRE1 = '0; AUTOFIRE2 = '0;
    step(3);
    chk("reset_p1", P1_IN, 10'h3FF);
    chk("reset_p2", P2_IN, 10'h3FF);
    RESET = 1'b0;
    step(2);

    // Single button: falls exactly 7 edges after the raw edge.
    JOY1_RAW[4] = 1'b1;
    step(6);
    chk("btnA_before_lat", P1_IN, 10'h3FF);
    step(1);
    chk("btnA_at_lat", P1_IN, 10'h3EF);
    step(5);
    JOY1_RAW = '0;
    step(12);

    // Glitch rejection and a pulse just above threshold.
    JOY2_RAW[8] = 1'b1; step(3); JOY2_RAW = '0;
    step(12);
    chk("short_pulse_p2", P2_IN, 10'h3FF);
    JOY2_RAW[8] = 1'b1; step(6); JOY2_RAW = '0;
    step(14);

    // SOCD up+down, then up only.
    JOY1_RAW = 10'h003; step(12);
    chk("socd_ud", P1_IN, 10'h3FF);
    JOY1_RAW = 10'h001; step(12);
    chk("socd_up", P1_IN, 10'h3FE);
    JOY1_RAW = 10'h00C; step(12);
    chk("socd_lr", P1_IN, 10'h3FF);
    JOY1_RAW = '0; step(12);

    // Reset mid-debounce discards the partial count.
    JOY1_RAW[5] = 1'b1; step(4);
    RESET = 1'b1; step(1);
    chk("mid_reset", P1_IN, 10'h3FF);
    RESET = 1'b0;
    step(6);
    chk("post_reset_pre", P1_IN, 10'h3FF);
    step(1);
    chk("post_reset_lat", P1_IN, 10'h3DF);
    JOY1_RAW = '0; step(12);

    // Simultaneous players.
    JOY1_RAW = 10'h300; JOY2_RAW = 10'h0F0;
    step(7);
    chk("simul_p1", P1_IN, 10'h0FF);
    chk("simul_p2", P2_IN, 10'h30F);
    JOY1_RAW = '0; JOY2_RAW = '0; step(12);

`ifdef C1_AUTOFIRE_EN
    AUTOFIRE1 = 4'b0001; JOY1_RAW[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      VBLANK = 1'b1; step(3); VBLANK = 1'b0; step(3);
    end
    AUTOFIRE1 = 4'b0000; step(1);
    chk("af_cleared", P1_IN, 10'h3EF);
    JOY1_RAW = '0; step(12);
`endif

    // Randomised holds of random vectors, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      JOY1_RAW  = 10'($urandom);
      JOY2_RAW  = 10'($urandom);
      AUTOFIRE1 = 4'($urandom);
      AUTOFIRE2 = 4'($urandom);
      VBLANK    = 1'($urandom);
      RESET     = ($urandom_range(0, 59) == 0);
      step(int'($urandom_range(1, 9)));
      RESET = 1'b0;
    end

    JOY1_RAW = '0; JOY2_RAW = '0; AUTOFIRE1 = '0; AUTOFIRE2 = '0; VBLANK = 1'b0;
    step(15);
    chk("final_p1", P1_IN, 10'h3FF);
    chk("final_p2", P2_IN, 10'h3FF);
    @(negedge CLK); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c1_joy_cond.md
Name: c1_joy_cond

Overview:
- Input conditioning stage directly upstream of the C1 input-port logic.
- Takes raw active-high player controls from the platform:
  - 8 directions/buttons per player.
  - Start and select per player.
- For each player it synchronises, debounces, resolves opposing directions (SOCD) and inverts the controls.
- Drives the active-low 10-bit P1_IN/P2_IN buses that the C1 register read-back (P1CNT, P2CNT, STATUS_B) consumes.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a bit changes; legal range 1..255.
- AUTOFIRE_FRAMES, 2, VBLANK rising edges per autofire half-period; legal range 1..15. Used only with C1_AUTOFIRE_EN.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- VBLANK  input  1  frame-rate strobe level. Synchronous to CLK. Used only with C1_AUTOFIRE_EN.
- JOY1_RAW  input  10  player 1 raw controls, active-high, asynchronous. Bit map:
  - [0] up, [1] down, [2] left, [3] right
  - [4] A, [5] B, [6] C, [7] D
  - [8] start, [9] select
- JOY2_RAW  input  10  player 2 raw controls, same bit map as JOY1_RAW.
- AUTOFIRE1  input  4  player 1 per-button autofire enable for A..D. Used only with C1_AUTOFIRE_EN.
- AUTOFIRE2  input  4  player 2 per-button autofire enable for A..D. Used only with C1_AUTOFIRE_EN.
- P1_IN  output  10  player 1 conditioned controls, active-low, registered, same bit map.
- P2_IN  output  10  player 2 conditioned controls, active-low, registered, same bit map.

Behaviour:
- Reset (RESET high at a clock edge):
  - P1_IN and P2_IN = 10'h3FF (all released).
  - Synchroniser flops, debounced state and debounce counters = 0.
  - Autofire phase = 0 and autofire frame counter = 0.
  - Reset wins over every other event on the same edge. Reset mid-debounce discards the partial count.
- Synchroniser: each raw bit passes through 2 flops; the output is "sync".
- Debounce, independent per bit (20 bits total):
  - Each bit has a state flop "stab" and a counter of 8 bits.
  - If sync == stab: counter cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stab <= sync and counter cleared.
  - Else: counter incremented.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stab.
  - The counter never wraps.
- SOCD, applied to stab per player:
  - up and down both set: both treated as released.
  - left and right both set: both treated as released.
  - Buttons, start and select pass through unchanged.
- Output: P*_IN <= ~(SOCD result), registered.
- Latency from a raw edge (setup met) to the P*_IN change = 2 + DEBOUNCE_CYCLES + 1 cycles. With the default this is 7.
- Players are fully independent; simultaneous edges on any bits are each handled within their own latency.

Optional Feature:
- Macro: C1_AUTOFIRE_EN.
- With the macro defined:
  - A VBLANK rising-edge detector (previous-value flop) drives a 4-bit frame counter.
  - When the counter reaches AUTOFIRE_FRAMES-1 on a rising edge, it clears and the shared phase bit toggles; otherwise the counter increments on each rising edge.
  - For a button with its AUTOFIRE bit set, the pre-inversion value = stab AND phase. The button therefore reads pressed only while held and phase = 1.
  - AUTOFIRE changes take effect on the next cycle; no debounce is applied to AUTOFIRE.
- Without the macro:
  - VBLANK, AUTOFIRE1 and AUTOFIRE2 are ignored.
  - No autofire logic is generated; buttons follow stab directly.

Test Plan:
1. Reset, then JOY1_RAW[4] 0->1 held; DEBOUNCE_CYCLES=4 -> P1_IN[4] goes 1->0 exactly 7 cycles after the raw edge; all other bits stay 1.
2. JOY2_RAW[8] pulse of 3 cycles -> P2_IN stays 10'h3FF. A pulse of 6 cycles -> P2_IN[8] is low for 6 cycles, starting at cycle 7.
3. JOY1_RAW = 10'h003 (up+down) held -> P1_IN = 10'h3FF. Change to 10'h001 -> P1_IN = 10'h3FE after debounce.
4. JOY1_RAW[5] held for 2 cycles past sync, then RESET for 1 cycle, RESET released with the raw bit still high -> P1_IN = 10'h3FF during reset; P1_IN[5] falls a full 7 cycles after reset release.
5. Simultaneous JOY1_RAW = 10'h300 and JOY2_RAW = 10'h0F0 -> on the same cycle, P1_IN = 10'h0FF and P2_IN = 10'h30F.
6. C1_AUTOFIRE_EN defined, AUTOFIRE_FRAMES=2, AUTOFIRE1 = 4'b0001, A held -> P1_IN[4] alternates low/high every 2 VBLANK rising edges. Clearing AUTOFIRE1 -> P1_IN[4] is solid 0 on the next cycle.
